mult_sched: RTL

Sequencer and round-robin arbiter for the shared 16-bit repeated-addition multiplier datapath (operand register A, product register P, down-counter B, adder, zero comparator). It accepts multiply requests from NREQ requesters and grants one at a time. For each granted request it drives the datapath load, clear and decrement strobes and the shared operand bus. It returns the product with a valid/ready response. It replaces the fixed one-shot control path with a reusable, backpressure-aware controller.

---
 rtl/mult_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter and sequencer for a shared
// repeated-addition multiplier datapath (A reg, P reg, B down-counter).
module mult_sched #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [W-1:0]      dp_din,
    output logic              dp_lda,
    output logic              dp_ldb,
    output logic              dp_ldp,
    output logic              dp_clrp,
    output logic              dp_decb,
    input  logic              dp_eqz,
    input  logic [W-1:0]      dp_prod
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_ITER,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   big_q, big_d;
    logic [W-1:0]   small_q, small_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [W-1:0]   a_sel, b_sel;

    // Round-robin search: first valid requester at or after ptr wins.
    always_comb begin
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[IDW'(j)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    assign a_sel = req_a[int'(gnt_idx)*W +: W];
    assign b_sel = req_b[int'(gnt_idx)*W +: W];

    // One-hot accept, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == S_IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state, register updates and Mealy datapath strobes.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        big_d      = big_q;
        small_d    = small_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        dp_din     = '0;
        dp_lda     = 1'b0;
        dp_ldb     = 1'b0;
        dp_ldp     = 1'b0;
        dp_clrp    = 1'b0;
        dp_decb    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    // Smaller operand goes to the counter: fewer iterations.
                    big_d    = (a_sel >= b_sel) ? a_sel : b_sel;
                    small_d  = (a_sel >= b_sel) ? b_sel : a_sel;
                    rsp_id_d = gnt_idx;
                    ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0
                             : gnt_idx + IDW'(1);
                    state_d  = S_LDA;
                end
            end
            S_LDA: begin
                dp_din  = big_q;
                dp_lda  = 1'b1;
                state_d = S_LDB;
            end
            S_LDB: begin
                dp_din  = small_q;
                dp_ldb  = 1'b1;
                dp_clrp = 1'b1;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!dp_eqz) begin
                    dp_ldp  = 1'b1;
                    dp_decb = 1'b1;
                end else begin
                    rsp_data_d = dp_prod;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and holding registers; reset abandons any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            big_q      <= big_d;
            small_q    <= small_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

endmodule
